// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter slice.
// Imported by the counter top, its next-state logic and the bench.
package counter_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Number of bits needed to hold 'value'; used to prove MODULUS-1 fits in WIDTH.
   function automatic int bitsToHold(input longint unsigned value);
      int n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         if ((value >> i) != 0) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle of one counter stage.
// The counter sits on the slave side; whoever drives it uses master.
interface mod_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             ld;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             ldErr;

   modport master (
      output en, up, ld, d,
      input  q, tc, wrap, ldErr
   );

   modport slave (
      input  en, up, ld, d,
      output q, tc, wrap, ldErr
   );
endinterface

// File: rtl/mod_updown_counter_next.sv
// Purely combinational next-count, event and terminal-count logic.
// Range compares are done one bit wider so MODULUS == 2**WIDTH is safe.
module counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic             up_i,
   input  logic             en_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] qNext_o,
   output logic             wrapNext_o,
   output logic             ldErrNext_o,
   output logic             tc_o
);

   localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] qWide;
   logic [WIDTH:0] dWide;
   logic           atTop;
   logic           atBottom;

   assign qWide    = {1'b0, q_i};
   assign dWide    = {1'b0, d_i};
   assign atTop    = (qWide == TOP);
   assign atBottom = (q_i == '0);

   // Load beats count; an out-of-range load clamps to the top of range and flags it.
   always_comb begin
      qNext_o     = q_i;
      wrapNext_o  = 1'b0;
      ldErrNext_o = 1'b0;
      if (ld_i) begin
         if (dWide <= TOP) begin
            qNext_o = d_i;
         end else begin
            qNext_o     = TOP[WIDTH-1:0];
            ldErrNext_o = 1'b1;
         end
      end else if (en_i) begin
         if (up_i == DIR_UP) begin
            if (!atTop) begin
               qNext_o = q_i + WIDTH'(1);
            end else if (SATURATE == MODE_WRAP) begin
               qNext_o    = '0;
               wrapNext_o = 1'b1;
            end
         end else begin
            if (!atBottom) begin
               qNext_o = q_i - WIDTH'(1);
            end else if (SATURATE == MODE_WRAP) begin
               qNext_o    = TOP[WIDTH-1:0];
               wrapNext_o = 1'b1;
            end
         end
      end
   end

   assign tc_o = en_i & ((up_i & atTop) | (~up_i & atBottom));

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with load, wrap/saturate mode and cascade carry.
// Holds the state registers; next-state decisions live in counter_next.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mod_updown_counter_if.slave     cnt_if
);

   if (WIDTH < 1 || MODULUS < 2 || bitsToHold(longint'(MODULUS - 1)) > WIDTH) begin : gBadParams
      $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ldErr_q, ldErr_d;

   counter_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS),
      .SATURATE(SATURATE)
   ) uNext (
      .q_i        (count_q),
      .up_i       (cnt_if.up),
      .en_i       (cnt_if.en),
      .ld_i       (cnt_if.ld),
      .d_i        (cnt_if.d),
      .qNext_o    (count_d),
      .wrapNext_o (wrap_d),
      .ldErrNext_o(ldErr_d),
      .tc_o       (cnt_if.tc)
   );

   // Event flags are re-evaluated every edge, so they self-clear after one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ldErr_q <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ldErr_q <= ldErr_d;
      end
   end

   assign cnt_if.q     = count_q;
   assign cnt_if.wrap  = wrap_q;
   assign cnt_if.ldErr = ldErr_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: wrap and saturate counters at MODULUS=10 plus a
// two-stage MODULUS=16 cascade, all checked against a behavioural model.
module tb_mod_updown_counter;
   import counter_pkg::*;

   typedef struct {
      int q;
      bit wrap;
      bit err;
   } expT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   mQ [2];
   int   mLo, mHi;
   expT  sb [$];
   expT  sbCasc [$];

   always #5 clk = ~clk;

   mod_updown_counter_if #(.WIDTH(4)) ifW ();
   mod_updown_counter_if #(.WIDTH(4)) ifS ();
   mod_updown_counter_if #(.WIDTH(4)) ifLo ();
   mod_updown_counter_if #(.WIDTH(4)) ifHi ();

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_WRAP)) dutW (
      .clk(clk), .rst_n(rst_n), .cnt_if(ifW.slave));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(MODE_SAT)) dutS (
      .clk(clk), .rst_n(rst_n), .cnt_if(ifS.slave));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(MODE_WRAP)) dutLo (
      .clk(clk), .rst_n(rst_n), .cnt_if(ifLo.slave));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(MODE_WRAP)) dutHi (
      .clk(clk), .rst_n(rst_n), .cnt_if(ifHi.slave));

   // Second stage advances only when the first stage reports terminal count.
   assign ifHi.en = ifLo.tc;
   assign ifHi.up = 1'b1;
   assign ifHi.ld = 1'b0;
   assign ifHi.d  = 4'd0;

   function automatic void modelNext(input int q, input bit en, input bit up, input bit ld,
                                     input int d, input int modulus, input bit sat,
                                     output int qn, output bit wr, output bit er);
      qn = q; wr = 1'b0; er = 1'b0;
      if (ld) begin
         if (d < modulus) qn = d;
         else begin qn = modulus - 1; er = 1'b1; end
      end else if (en) begin
         if (up) begin
            if (q < modulus - 1) qn = q + 1;
            else if (!sat) begin qn = 0; wr = 1'b1; end
         end else begin
            if (q > 0) qn = q - 1;
            else if (!sat) begin qn = modulus - 1; wr = 1'b1; end
         end
      end
   endfunction

   function automatic bit modelTc(input int q, input bit en, input bit up, input int modulus);
      return en && ((up && q == modulus - 1) || (!up && q == 0));
   endfunction

   task automatic checkOutput(input string tag, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   // One clock of stimulus on counter sel (0 = wrap, 1 = saturate); the other idles.
   task automatic applyStimulus(input int sel, input bit en, input bit up, input bit ld, input int d);
      expT e, got;
      int  qn;
      bit  wr, er;
      ifW.en = (sel == 0) ? en : 1'b0;
      ifW.up = up;
      ifW.ld = (sel == 0) ? ld : 1'b0;
      ifW.d  = 4'(d);
      ifS.en = (sel == 1) ? en : 1'b0;
      ifS.up = up;
      ifS.ld = (sel == 1) ? ld : 1'b0;
      ifS.d  = 4'(d);
      #1;
      checkOutput(sel == 0 ? "W.tc" : "S.tc", sel == 0 ? int'(ifW.tc) : int'(ifS.tc),
                  int'(modelTc(mQ[sel], en, up, 10)));
      modelNext(mQ[sel], en, up, ld, d, 10, sel == 1, qn, wr, er);
      mQ[sel] = qn;
      e.q = qn; e.wrap = wr; e.err = er;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      got.q    = (sel == 0) ? int'(ifW.q) : int'(ifS.q);
      got.wrap = (sel == 0) ? ifW.wrap : ifS.wrap;
      got.err  = (sel == 0) ? ifW.ldErr : ifS.ldErr;
      checkOutput(sel == 0 ? "W.q" : "S.q", got.q, e.q);
      checkOutput(sel == 0 ? "W.wrap" : "S.wrap", int'(got.wrap), int'(e.wrap));
      checkOutput(sel == 0 ? "W.ldErr" : "S.ldErr", int'(got.err), int'(e.err));
   endtask

   task automatic stepCascade();
      expT eLo, eHi;
      int  qn;
      bit  wr, er, hiEn;
      hiEn = modelTc(mLo, 1'b1, 1'b1, 16);
      modelNext(mLo, 1'b1, 1'b1, 1'b0, 0, 16, 1'b0, qn, wr, er);
      mLo = qn; eLo.q = qn; eLo.wrap = wr; eLo.err = er;
      modelNext(mHi, hiEn, 1'b1, 1'b0, 0, 16, 1'b0, qn, wr, er);
      mHi = qn; eHi.q = qn; eHi.wrap = wr; eHi.err = er;
      sbCasc.push_back(eLo);
      sbCasc.push_back(eHi);
      @(posedge clk);
      #1;
      eLo = sbCasc.pop_front();
      eHi = sbCasc.pop_front();
      checkOutput("Lo.q", int'(ifLo.q), eLo.q);
      checkOutput("Hi.q", int'(ifHi.q), eHi.q);
      checkOutput("Lo.wrap", int'(ifLo.wrap), int'(eLo.wrap));
      checkOutput("Hi.wrap", int'(ifHi.wrap), int'(eHi.wrap));
   endtask

   task automatic asyncReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rst.W.q", int'(ifW.q), 0);
      checkOutput("rst.W.wrap", int'(ifW.wrap), 0);
      checkOutput("rst.W.ldErr", int'(ifW.ldErr), 0);
      checkOutput("rst.S.q", int'(ifS.q), 0);
      mQ[0] = 0; mQ[1] = 0; mLo = 0; mHi = 0;
      sb.delete();
      sbCasc.delete();
   endtask

   initial begin
      ifW.en = 0; ifW.up = 1; ifW.ld = 0; ifW.d = 0;
      ifS.en = 0; ifS.up = 1; ifS.ld = 0; ifS.d = 0;
      ifLo.en = 0; ifLo.up = 1; ifLo.ld = 0; ifLo.d = 0;
      mQ[0] = 0; mQ[1] = 0; mLo = 0; mHi = 0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("init.W.q", int'(ifW.q), 0);
      rst_n = 1'b1;

      // Reset mid-count, hold through an edge, then count one after release.
      applyStimulus(0, 1, 1, 1, 7);
      asyncReset();
      ifW.en = 1; ifW.up = 1;
      @(posedge clk);
      #1;
      checkOutput("rstHold.W.q", int'(ifW.q), 0);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 1, 1, 0, 0);

      // Up through the full range with wrap, then past it.
      applyStimulus(0, 1, 1, 1, 0);
      for (int i = 0; i < 11; i++) applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);

      // Down wrap and immediate direction reversal.
      applyStimulus(0, 1, 1, 1, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);

      // Loads: in range, out of range, boundary values, load at top of range.
      applyStimulus(0, 1, 1, 1, 5);
      applyStimulus(0, 1, 1, 1, 12);
      applyStimulus(0, 1, 1, 1, 3);
      applyStimulus(0, 0, 0, 1, 10);
      applyStimulus(0, 1, 1, 1, 15);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 9);
      applyStimulus(0, 0, 1, 0, 0);

      // Saturating counter: hold at both ends.
      applyStimulus(1, 1, 1, 1, 7);
      for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 1, 0);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 14);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                        int'($urandom_range(0, 15)));
      end

      // Cascade: full 256-state range of two chained stages.
      @(posedge clk);
      #2;
      asyncReset();
      #1;
      rst_n = 1'b1;
      ifLo.en = 1'b1;
      for (int i = 0; i < 255; i++) stepCascade();
      checkOutput("casc255.Lo.q", int'(ifLo.q), 15);
      checkOutput("casc255.Hi.q", int'(ifHi.q), 15);
      stepCascade();
      checkOutput("casc256.Hi.wrap", int'(ifHi.wrap), 1);
      stepCascade();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous successor to the 4-bit ripple counter: all state bits clocked by CLK, with no derived clocks.
- Adds programmable width and modulus, up/down direction, parallel load, count enable, and wrap or saturate mode.
- Provides a combinational terminal-count output for cascading stages and registered event pulses for wrap and load error.
- Used as the general-purpose counter and timer primitive in lab datapaths.

Parameters:
- WIDTH, 4, counter width in bits (>=1).
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0. 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  count enable.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- LD  in  1  synchronous parallel load; has priority over EN.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current count (registered).
- TC  out  1  terminal count, combinational (cascade carry/borrow).
- WRAP  out  1  registered one-cycle pulse: a wrap occurred on the previous edge.
- LD_ERR  out  1  registered one-cycle pulse: D was out of range at load.

Behaviour:
- Reset:
  - RST=0 forces Q=0, WRAP=0, LD_ERR=0 immediately, independent of CLK.
  - Release is sampled at the next rising edge.
  - Reset mid-count discards all state; no pulse is generated on release.
- Priority per rising edge: LD, then EN, then hold.
- LD=1:
  - If D <= MODULUS-1: Q <= D, LD_ERR <= 0.
  - Otherwise: Q <= MODULUS-1, LD_ERR <= 1.
  - WRAP <= 0 in both cases.
  - EN and UP are ignored in a load cycle.
- LD=0, EN=1, UP=1:
  - Q < MODULUS-1: Q <= Q+1.
  - Q = MODULUS-1, SATURATE=0: Q <= 0, WRAP <= 1.
  - Q = MODULUS-1, SATURATE=1: Q holds, WRAP <= 0.
- LD=0, EN=1, UP=0:
  - Q > 0: Q <= Q-1.
  - Q = 0, SATURATE=0: Q <= MODULUS-1, WRAP <= 1.
  - Q = 0, SATURATE=1: Q holds, WRAP <= 0.
- LD=0, EN=0: Q holds; WRAP <= 0, LD_ERR <= 0.
- Pulse clearing: WRAP and LD_ERR are high for exactly one cycle unless re-triggered on consecutive edges.
- Terminal count:
  - TC = EN & ((UP & Q==MODULUS-1) | (~UP & Q==0)).
  - TC is combinational, so the next stage's EN can be tied to this stage's TC.
  - TC is unaffected by LD.
  - In saturate mode TC stays high while held at the end of range with EN=1.
- Arithmetic:
  - Compare and next-state logic are computed at WIDTH+1 bits, so MODULUS = 2**WIDTH does not overflow.
  - Q never leaves 0..MODULUS-1 after reset.
- Direction change: UP may change on any cycle; it takes effect at the next edge with no dead cycle.
- Latency: Q reflects LD or EN one edge after sampling; WRAP and LD_ERR assert on that same edge.

Decomposition:
- Package counter_pkg:
  - Mode constants MODE_WRAP=0 and MODE_SAT=1.
  - Direction constants DIR_DOWN=0 and DIR_UP=1.
  - Function for the clog2-style width check used in the parameter assertion.
- Sub-module counter_next (purely combinational):
  - Inputs: Q, UP, EN, LD, D.
  - Outputs: next Q, wrap_n, ld_err_n, TC.
- Top level: the registers, the asynchronous reset, and elaboration-time parameter checks (MODULUS range).

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset: RST=0 mid-count with Q=7 -> Q=0, WRAP=0, LD_ERR=0 before the next edge; hold RST=1, EN=1, UP=1 -> Q=1 one edge after release.
- Up wrap (SATURATE=0), EN=1, UP=1 from 0:
  - Q steps 0..9; TC=1 at Q=9.
  - Next edge: Q=0, WRAP=1 for one cycle, then 0.
- Down wrap: Q=0, UP=0, EN=1 -> TC=1; next edge Q=9, WRAP=1. Toggling UP between edges reverses direction immediately.
- Saturate (SATURATE=1): count up to 9 and hold EN=1 for 3 edges -> Q stays 9, TC=1, WRAP never 1. UP=0 -> Q=8 next edge.
- Load: LD=1, D=5, EN=1 -> Q=5, LD_ERR=0. Then LD=1, D=12 -> Q=9, LD_ERR=1 for one cycle. LD=1 while Q=9, UP=1 -> no WRAP.
- Cascade and full range: two instances, the second's EN tied to the first's TC, WIDTH=4, MODULUS=16 -> after 255 edges both Q=15. On the 256th edge both become 0 and both WRAP pulse on the same cycle.
